// File: rtl/axi_master_pkg.sv
// Shared definitions for the CPU-side AXI4 masters: bus widths, the master
// FSM state encoding and the fixed single-beat AXI field values.
package axi_master_pkg;

  localparam int unsigned AXI_ID_BITS   = 4;
  localparam int unsigned AXI_ADDR_BITS = 32;
  localparam int unsigned AXI_DATA_BITS = 32;
  localparam int unsigned AXI_STRB_BITS = AXI_DATA_BITS / 8;
  localparam int unsigned AXI_LEN_BITS  = 4;
  localparam int unsigned AXI_SIZE_BITS = 3;

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StAwW,
    StB
  } axi_state_e;

  localparam logic [1:0]              BURST_INCR = 2'b01;
  localparam logic [AXI_SIZE_BITS-1:0] SIZE_WORD  = 3'b010;
  localparam logic [AXI_LEN_BITS-1:0]  LEN_SINGLE = 4'd0;
  localparam logic [1:0]              RESP_OKAY  = 2'b00;

endpackage

// File: rtl/dm_axi_master.sv
// Data-memory AXI4 master: turns MEM-stage load/store strobes into single-beat
// AXI transactions and stalls the core until they complete. Optional DM_RESP_CHECK_EN.
module dm_axi_master
  import axi_master_pkg::*;
#(
  parameter logic [AXI_ID_BITS-1:0] MASTER_ID = 4'd1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     b_data_read,
  input  logic                     b_data_write,
  input  logic [AXI_STRB_BITS-1:0] write_type,
  input  logic [AXI_ADDR_BITS-1:0] data_addr,
  input  logic [AXI_DATA_BITS-1:0] data_in,
  output logic [AXI_DATA_BITS-1:0] data_out,
  output logic                     DM_stall,
  output logic                     bus_err,
  output logic [AXI_ID_BITS-1:0]   ARID,
  output logic [AXI_ADDR_BITS-1:0] ARADDR,
  output logic [AXI_LEN_BITS-1:0]  ARLEN,
  output logic [AXI_SIZE_BITS-1:0] ARSIZE,
  output logic [1:0]               ARBURST,
  output logic                     ARVALID,
  input  logic                     ARREADY,
  input  logic [AXI_ID_BITS-1:0]   RID,
  input  logic [AXI_DATA_BITS-1:0] RDATA,
  input  logic [1:0]               RRESP,
  input  logic                     RLAST,
  input  logic                     RVALID,
  output logic                     RREADY,
  output logic [AXI_ID_BITS-1:0]   AWID,
  output logic [AXI_ADDR_BITS-1:0] AWADDR,
  output logic [AXI_LEN_BITS-1:0]  AWLEN,
  output logic [AXI_SIZE_BITS-1:0] AWSIZE,
  output logic [1:0]               AWBURST,
  output logic                     AWVALID,
  input  logic                     AWREADY,
  output logic [AXI_DATA_BITS-1:0] WDATA,
  output logic [AXI_STRB_BITS-1:0] WSTRB,
  output logic                     WLAST,
  output logic                     WVALID,
  input  logic                     WREADY,
  input  logic [AXI_ID_BITS-1:0]   BID,
  input  logic [1:0]               BRESP,
  input  logic                     BVALID,
  output logic                     BREADY
);

  axi_state_e               state_q, state_d;
  logic [AXI_ADDR_BITS-1:0] addr_q;
  logic [AXI_DATA_BITS-1:0] wdata_q, rdata_q;
  logic [AXI_STRB_BITS-1:0] wtype_q;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;
  logic                     latch;
  logic                     r_fire, b_fire;

  assign r_fire = (state_q == StR) && RVALID;
  assign b_fire = (state_q == StB) && BVALID;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    latch     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Store wins when both strobes are raised together.
        if (b_data_write) begin
          state_d   = StAwW;
          latch     = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else if (b_data_read) begin
          state_d = StAr;
          latch   = 1'b1;
        end
      end
      StAr: if (ARREADY) state_d = StR;
      StR:  if (RVALID) state_d = StIdle;
      StAwW: begin
        if (AWREADY && !aw_done_q) aw_done_d = 1'b1;
        if (WREADY && !w_done_q)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d   = StB;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      StB:     if (BVALID) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wtype_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (latch) begin
        addr_q  <= data_addr;
        wdata_q <= data_in;
        wtype_q <= write_type;
      end
      if (r_fire) rdata_q <= RDATA;
    end
  end

  assign ARID    = MASTER_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = LEN_SINGLE;
  assign ARSIZE  = SIZE_WORD;
  assign ARBURST = BURST_INCR;
  assign ARVALID = (state_q == StAr);
  assign RREADY  = (state_q == StR);

  assign AWID    = MASTER_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = LEN_SINGLE;
  assign AWSIZE  = SIZE_WORD;
  assign AWBURST = BURST_INCR;
  assign AWVALID = (state_q == StAwW) && !aw_done_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = ~wtype_q;
  assign WLAST   = 1'b1;
  assign WVALID  = (state_q == StAwW) && !w_done_q;
  assign BREADY  = (state_q == StB);

  // The completing cycle releases the core so it advances on that edge.
  assign DM_stall = ((state_q == StIdle) && (b_data_read || b_data_write)) ||
                    ((state_q != StIdle) && !r_fire && !b_fire);
  assign data_out = r_fire ? RDATA : rdata_q;

`ifdef DM_RESP_CHECK_EN
  logic bus_err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err_q <= 1'b0;
    end else if ((r_fire && (RRESP != RESP_OKAY)) || (b_fire && (BRESP != RESP_OKAY))) begin
      bus_err_q <= 1'b1;
    end
  end
  assign bus_err = bus_err_q;
  logic unused_inputs;
  assign unused_inputs = ^{RID, BID, RLAST};
`else
  assign bus_err = 1'b0;
  logic unused_inputs;
  assign unused_inputs = ^{RID, BID, RLAST, RRESP, BRESP};
`endif

endmodule

// File: tb/tb_dm_axi_master.sv
// Scoreboard bench for dm_axi_master: randomized loads/stores against a
// delay-programmable AXI slave, with a transaction-level expectation queue.
module tb_dm_axi_master;
  import axi_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        b_data_read, b_data_write;
  logic [3:0]  write_type;
  logic [31:0] data_addr, data_in, data_out;
  logic        DM_stall, bus_err;
  logic [3:0]  ARID, AWID, RID, BID, ARLEN, AWLEN;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic [3:0]  WSTRB;

  always #5 clk = ~clk;

  dm_axi_master #(.MASTER_ID(4'd1)) dut (
    .clk(clk), .rst(rst), .b_data_read(b_data_read), .b_data_write(b_data_write),
    .write_type(write_type), .data_addr(data_addr), .data_in(data_in),
    .data_out(data_out), .DM_stall(DM_stall), .bus_err(bus_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          ar_d, r_d, aw_d, w_d, b_d;
    int          stall;
    logic [31:0] last_rdata;
    bit          err_before;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  int          checks = 0;
  int          errors = 0;
  bit          err_model = 1'b0;
  logic [31:0] last_rdata_model = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- AXI slave with per-transaction wait counts ----------------
  int ar_w, r_w, aw_w, w_w, b_w;
  bit r_pend, aw_seen, w_seen, b_pend;

  task automatic slave_clear();
    ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
    r_pend = 0; aw_seen = 0; w_seen = 0; b_pend = 0;
  endtask

  initial begin
    ARREADY = 0; RVALID = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
    RID = 4'd1; BID = 4'd1; RLAST = 1'b1; RDATA = 0; RRESP = 0; BRESP = 0;
    slave_clear();
    forever begin
      @(negedge clk);
      if (rst) begin
        slave_clear();
        ARREADY = 0; RVALID = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
        continue;
      end
      ARREADY = (ar_w == cur.ar_d);
      RVALID  = r_pend && (r_w == cur.r_d);
      RDATA   = RVALID ? cur.rdata : $urandom();
      RRESP   = cur.resp;
      AWREADY = (aw_w == cur.aw_d);
      WREADY  = (w_w == cur.w_d);
      BVALID  = b_pend && (b_w == cur.b_d);
      BRESP   = cur.resp;
      #4;
      if (rst) begin
        slave_clear();
        continue;
      end
      if (RVALID && RREADY) r_pend = 0; else if (r_pend) r_w++;
      if (ARVALID && ARREADY) begin ar_w = 0; r_pend = 1; r_w = 0; end
      else if (ARVALID) ar_w++;
      if (BVALID && BREADY) b_pend = 0; else if (b_pend) b_w++;
      if (AWVALID && AWREADY) begin aw_seen = 1; aw_w = 0; end
      else if (AWVALID) aw_w++;
      if (WVALID && WREADY) begin w_seen = 1; w_w = 0; end
      else if (WVALID) w_w++;
      if (aw_seen && w_seen) begin b_pend = 1; b_w = 0; aw_seen = 0; w_seen = 0; end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    txn_t e;
    int   stall_cnt;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        stall_cnt = 0;
        continue;
      end
      if (DM_stall) stall_cnt++;
      if (ARVALID && ARREADY) begin
        if (exp_q.size() == 0) check("ar_unexpected", 32'd1, 32'd0);
        else begin
          check("ar_is_read", {31'd0, exp_q[0].is_write}, 32'd0);
          check("araddr", ARADDR, exp_q[0].addr);
          check("ar_fixed", {ARID, ARLEN, 1'b0, ARSIZE, ARBURST}, {4'd1, 4'd0, 1'b0, 3'd2, 2'b01});
        end
      end
      if (AWVALID && AWREADY) begin
        if (exp_q.size() == 0) check("aw_unexpected", 32'd1, 32'd0);
        else begin
          check("aw_is_write", {31'd0, exp_q[0].is_write}, 32'd1);
          check("awaddr", AWADDR, exp_q[0].addr);
          check("aw_fixed", {AWID, AWLEN, 1'b0, AWSIZE, AWBURST}, {4'd1, 4'd0, 1'b0, 3'd2, 2'b01});
        end
      end
      if (WVALID && WREADY) begin
        if (exp_q.size() == 0) check("w_unexpected", 32'd1, 32'd0);
        else begin
          check("wdata", WDATA, exp_q[0].wdata);
          check("wstrb_wlast", {WSTRB, WLAST}, {exp_q[0].wstrb, 1'b1});
        end
      end
      if ((RVALID && RREADY) || (BVALID && BREADY)) begin
        if (exp_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("done_kind", {31'd0, BVALID && BREADY}, {31'd0, e.is_write});
          check("done_stall_low", {31'd0, DM_stall}, 32'd0);
          check("stall_cycles", stall_cnt, e.stall);
          check("bus_err", {31'd0, bus_err}, {31'd0, e.err_before});
          check("data_out", data_out, e.is_write ? e.last_rdata : e.rdata);
        end
        stall_cnt = 0;
      end
    end
  end

  // ---------------- stimulus and reference model ----------------
  function automatic txn_t mk(bit w, logic [31:0] a, logic [31:0] wd, logic [3:0] st,
                              logic [31:0] rd, logic [1:0] resp,
                              int ard, int rdd, int awd, int wdd, int bd);
    txn_t t;
    t.is_write = w; t.addr = a; t.wdata = wd; t.wstrb = st; t.rdata = rd; t.resp = resp;
    t.ar_d = ard; t.r_d = rdd; t.aw_d = awd; t.w_d = wdd; t.b_d = bd;
    t.stall = 0; t.last_rdata = 0; t.err_before = 0;
    return t;
  endfunction

  function automatic int rdelay();
    return ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
  endfunction

  function automatic txn_t rand_txn();
    return mk($urandom_range(0, 1) == 1, $urandom() & 32'hFFFF_FFFC, $urandom(),
              4'($urandom_range(0, 15)), $urandom(),
              ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00,
              rdelay(), rdelay(), rdelay(), rdelay(), rdelay());
  endfunction

  // Called at a negedge; returns at the negedge after the core has advanced.
  task automatic issue(input txn_t t_in, input bit both, output bit ok);
    txn_t t;
    t = t_in;
    // One IDLE cycle, the address phase, then any data/response wait cycles.
    if (t.is_write) t.stall = 2 + ((t.aw_d > t.w_d) ? t.aw_d : t.w_d) + t.b_d;
    else            t.stall = 2 + t.ar_d + t.r_d;
    t.err_before = err_model;
    t.last_rdata = last_rdata_model;
    cur = t;
    exp_q.push_back(t);
    b_data_write = t.is_write;
    b_data_read  = !t.is_write || both;
    write_type   = ~t.wstrb;
    data_addr    = t.addr;
    data_in      = t.wdata;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      #4;
      if (!DM_stall) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    b_data_read  = 0;
    b_data_write = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL completion_timeout: got no completion, expected within 200 cycles");
    end
    if (!t.is_write) last_rdata_model = t.rdata;
`ifdef DM_RESP_CHECK_EN
    if (t.resp != RESP_OKAY) err_model = 1'b1;
`endif
  endtask

  initial begin : driver
    bit   ok;
    txn_t dir[6];
    rst = 1'b1;
    b_data_read = 0; b_data_write = 0; write_type = 4'hF; data_addr = 0; data_in = 0;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #2;
    check("rst_valids", {27'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'd0);
    check("rst_stall_err", {30'd0, DM_stall, bus_err}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    dir[0] = mk(0, 32'h0001_0004, 0, 0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0);
    dir[1] = mk(1, 32'h0002_0000, 32'h0000_00A5, 4'b0001, 0, 2'b00, 0, 0, 0, 0, 0);
    dir[2] = mk(1, 32'h0002_0010, 32'h1122_3344, 4'b1111, 0, 2'b00, 0, 0, 3, 0, 1);
    dir[3] = mk(1, 32'h0003_0000, 32'h5566_7788, 4'b0000, 0, 2'b00, 0, 0, 0, 0, 0);
    dir[4] = mk(1, 32'h0003_0004, 32'hCAFE_F00D, 4'b1100, 0, 2'b10, 0, 0, 1, 2, 0);
    dir[5] = mk(0, 32'h0004_0008, 0, 0, 32'h1234_5678, 2'b00, 1, 2, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      issue(dir[i], i == 3, ok);
      if (!ok) break;
    end

    // Reset in the middle of a load's data phase.
    if (ok) begin
      cur = mk(0, 32'h0005_0000, 0, 0, 32'hABCD_0123, 2'b00, 0, 30, 0, 0, 0);
      exp_q.push_back(cur);
      b_data_read = 1;
      data_addr = cur.addr;
      repeat (3) @(negedge clk);
      #1;
      check("in_r_before_rst", {31'd0, RREADY}, 32'd1);
      #1;
      b_data_read = 0;
      rst = 1'b1;
      #1;
      check("async_rst_valids", {27'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'd0);
      check("async_rst_stall", {31'd0, DM_stall}, 32'd0);
      check("async_rst_data", data_out, 32'd0);
      exp_q.delete();
      last_rdata_model = 32'h0;
      err_model = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      issue(mk(0, 32'h0006_0000, 0, 0, 32'h0BAD_F00D, 2'b00, 0, 0, 0, 0, 0), 0, ok);
    end

    for (int i = 0; i < 80 && ok; i++) begin
      issue(rand_txn(), $urandom_range(0, 3) == 0, ok);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    #4;
    check("final_bus_err", {31'd0, bus_err}, {31'd0, err_model});
    check("final_data_out", data_out, last_rdata_model);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
